// File: rtl/pam4_frame_pkg.sv
// rtl/pam4_frame_pkg.sv - shared types and constants for the framed PAM-4 symbol source
//
// Purpose: state enum, PRBS seed, preamble symbol values and checksum length.
// Optional feature macro: PAYLOAD_CHECKSUM_EN (adds the CHECK state).
package pam4_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_PAYLOAD  = 3'd2,
`ifdef PAYLOAD_CHECKSUM_EN
    ST_CHECK    = 3'd3,
`endif
    ST_GAP      = 3'd4
  } state_e;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [1:0] SYM_HI     = 2'b11;
  localparam logic [1:0] SYM_LO     = 2'b00;
  localparam int         CHK_SYMS   = 4;

endpackage

// File: rtl/prbs7_2sym.sv
// rtl/prbs7_2sym.sv - PRBS7 (x^7+x^6+1) LFSR producing two bits per advance
//
// Ports:
//   clk     - symbol clock
//   rst     - synchronous active-high reset, reseeds to PRBS7_SEED
//   load    - reseed to PRBS7_SEED (takes priority over advance)
//   advance - shift the LFSR by two bits
//   sym     - the two bits the next advance produces, {first, second}
module prbs7_2sym
  import pam4_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] sym
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic       bit_a;
  logic       bit_b;

  // Two serial steps unrolled: the second new bit is s[6]^s[5] of the
  // once-shifted register, which is s[5]^s[4] of the current one.
  assign bit_a = lfsr_q[6] ^ lfsr_q[5];
  assign bit_b = lfsr_q[5] ^ lfsr_q[4];
  assign sym   = {bit_a, bit_b};

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = PRBS7_SEED;
    end else if (advance) begin
      lfsr_d = {lfsr_q[4:0], bit_a, bit_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/pam4_frame_gen.sv
// rtl/pam4_frame_gen.sv - framed PAM-4 symbol source: preamble, PRBS7 payload, idle gap
//
// Ports:
//   clk          - symbol clock (clk_x1)
//   rst          - synchronous active-high reset
//   send_enable  - single-cycle start pulse (ignored while busy)
//   send_stop    - single-cycle stop pulse; the running frame always completes
//   data_out     - registered 2-bit PAM-4 symbol
//   frame_start  - high with the first preamble symbol of each frame
//   busy         - high in every state except IDLE
//   frame_count  - completed frames, wraps modulo 2^CNT_W
// Optional feature macro: PAYLOAD_CHECKSUM_EN appends a 4-symbol mod-256
// sum of the payload symbols between PAYLOAD and GAP.
module pam4_frame_gen
  import pam4_frame_pkg::*;
#(
  parameter int PREAMBLE_LEN = 16,
  parameter int PAYLOAD_LEN  = 64,
  parameter int GAP_LEN      = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_enable,
  input  logic             send_stop,
  output logic [1:0]       data_out,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int MAX_LEN =
    (PREAMBLE_LEN > PAYLOAD_LEN) ?
      ((PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN) :
      ((PAYLOAD_LEN  > GAP_LEN) ? PAYLOAD_LEN  : GAP_LEN);
  localparam int SYM_W = $clog2(MAX_LEN + 1);

  localparam logic [SYM_W-1:0] PRE_LAST = SYM_W'(PREAMBLE_LEN - 1);
  localparam logic [SYM_W-1:0] PAY_LAST = SYM_W'(PAYLOAD_LEN - 1);
  localparam logic [SYM_W-1:0] GAP_LAST = SYM_W'(GAP_LEN - 1);
  localparam logic [SYM_W-1:0] CNT_ONE  = SYM_W'(1);

  state_e           state_q, state_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [1:0]       data_q, data_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             stop_req_q, stop_req_d;
  logic             prbs_load;
  logic             prbs_advance;
  logic [1:0]       prbs_sym;
`ifdef PAYLOAD_CHECKSUM_EN
  localparam logic [SYM_W-1:0] CHK_LAST = SYM_W'(CHK_SYMS - 1);
  logic [7:0]       sum_q, sum_d;
`endif

  prbs7_2sym u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (prbs_load),
    .advance (prbs_advance),
    .sym     (prbs_sym)
  );

  always_comb begin
    state_d       = state_q;
    sym_cnt_d     = sym_cnt_q;
    data_d        = SYM_LO;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    stop_req_d    = stop_req_q;
    prbs_load     = 1'b0;
    prbs_advance  = 1'b0;
`ifdef PAYLOAD_CHECKSUM_EN
    sum_d         = sum_q;
`endif

    if ((state_q != ST_IDLE) && send_stop) begin
      stop_req_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels the start.
        if (send_enable && !send_stop) begin
          state_d       = ST_PREAMBLE;
          sym_cnt_d     = PRE_LAST;
          data_d        = SYM_HI;
          frame_start_d = 1'b1;
          prbs_load     = 1'b1;
`ifdef PAYLOAD_CHECKSUM_EN
          sum_d         = 8'd0;
`endif
        end
      end

      ST_PREAMBLE: begin
        if (sym_cnt_q != '0) begin
          sym_cnt_d = sym_cnt_q - CNT_ONE;
          // PREAMBLE_LEN is even, so an odd count means the next symbol
          // sits at an odd index and is the low level.
          data_d    = sym_cnt_q[0] ? SYM_LO : SYM_HI;
        end else begin
          state_d      = ST_PAYLOAD;
          sym_cnt_d    = PAY_LAST;
          data_d       = prbs_sym;
          prbs_advance = 1'b1;
`ifdef PAYLOAD_CHECKSUM_EN
          sum_d        = sum_q + {6'd0, prbs_sym};
`endif
        end
      end

      ST_PAYLOAD: begin
        if (sym_cnt_q != '0) begin
          sym_cnt_d    = sym_cnt_q - CNT_ONE;
          data_d       = prbs_sym;
          prbs_advance = 1'b1;
`ifdef PAYLOAD_CHECKSUM_EN
          sum_d        = sum_q + {6'd0, prbs_sym};
`endif
        end else begin
`ifdef PAYLOAD_CHECKSUM_EN
          state_d   = ST_CHECK;
          sym_cnt_d = CHK_LAST;
          data_d    = sum_q[7:6];
`else
          state_d   = ST_GAP;
          sym_cnt_d = GAP_LAST;
`endif
        end
      end

`ifdef PAYLOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (sym_cnt_q != '0) begin
          sym_cnt_d = sym_cnt_q - CNT_ONE;
          if (sym_cnt_q == SYM_W'(3)) begin
            data_d = sum_q[5:4];
          end else if (sym_cnt_q == SYM_W'(2)) begin
            data_d = sum_q[3:2];
          end else begin
            data_d = sum_q[1:0];
          end
        end else begin
          state_d   = ST_GAP;
          sym_cnt_d = GAP_LAST;
        end
      end
`endif

      ST_GAP: begin
        if (sym_cnt_q != '0) begin
          sym_cnt_d = sym_cnt_q - CNT_ONE;
        end else begin
          frame_count_d = frame_count_q + CNT_W'(1);
          if (stop_req_q || send_stop) begin
            state_d = ST_IDLE;
          end else begin
            state_d       = ST_PREAMBLE;
            sym_cnt_d     = PRE_LAST;
            data_d        = SYM_HI;
            frame_start_d = 1'b1;
            prbs_load     = 1'b1;
`ifdef PAYLOAD_CHECKSUM_EN
            sum_d         = 8'd0;
`endif
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_IDLE) begin
      stop_req_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sym_cnt_q     <= '0;
      data_q        <= SYM_LO;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      stop_req_q    <= 1'b0;
`ifdef PAYLOAD_CHECKSUM_EN
      sum_q         <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      sym_cnt_q     <= sym_cnt_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      stop_req_q    <= stop_req_d;
`ifdef PAYLOAD_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule
